// File: rtl/led_pattern_sched.sv
// led_pattern_sched: pattern engine and fixed-priority arbiter for the two
// bicolour status LEDs. Requester 1 (fault monitor) always wins over
// requester 0 (host status). A free-running prescaler produces a PWM tick and
// an 8-bit sawtooth. Each full sawtooth sweep is one frame, and the pattern
// timing is built from those frames.
module led_pattern_sched #(
    parameter int unsigned TICK_DIV = 250   // clk cycles per PWM tick, 2..2^24
) (
    input  logic       clk,
    input  logic       arstn,
    input  logic [1:0] cmd_valid,
    output logic [1:0] cmd_ready,
    input  logic [2:0] cmd_pattern0,
    input  logic [2:0] cmd_pattern1,
    input  logic [3:0] cmd_mask0,
    input  logic [3:0] cmd_mask1,
    input  logic [3:0] cmd_arg0,
    input  logic [3:0] cmd_arg1,
    output logic [1:0] green,
    output logic [1:0] blue,
    output logic       busy,
    output logic       owner
);

    localparam int unsigned        CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TICK_DIV - 1);

    // State codes match the command pattern codes 1..4, so an accepted
    // command loads its pattern straight into the state register.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SOLID   = 3'd1,
        ST_BLINK   = 3'd2,
        ST_BREATHE = 3'd3,
        ST_FLASH   = 3'd4
    } state_e;

    // The up direction is encoded as 0 so the reset value is a valid start.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [7:0]       saw_q,   saw_d;
    state_e           state_q, state_d;
    logic [3:0]       mask_q,  mask_d;
    logic             owner_q, owner_d;
    logic [7:0]       lvl_q,   lvl_d;
    dir_e             dir_q,   dir_d;
    logic             phase_q, phase_d;
    logic [4:0]       flcnt_q, flcnt_d;   // 5 bits so an argument of 0 can load 16

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic       tick;
    logic       frame_end;
    logic       ready0;
    logic       hs0;
    logic       hs1;
    logic       hs_any;
    logic [2:0] sel_pattern;
    logic [3:0] sel_mask;
    logic [3:0] sel_arg;
    logic       sel_owner;
    logic       led_on;

    // Prescaler and sawtooth: free running, never touched by commands.
    always_comb begin
        tick      = (cnt_q == CNT_MAX);
        frame_end = tick && (saw_q == 8'hFF);
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        saw_d     = tick ? saw_q + 8'd1 : saw_q;
    end

    // Ready/arbitration: requester 1 is always accepted. Requester 0 is
    // refused whenever requester 1 is presenting or owns the LEDs.
    always_comb begin
        ready0      = !cmd_valid[1] && !((state_q != ST_IDLE) && owner_q);
        hs1         = cmd_valid[1];
        hs0         = cmd_valid[0] && ready0;
        hs_any      = hs0 || hs1;
        sel_pattern = hs1 ? cmd_pattern1 : cmd_pattern0;
        sel_mask    = hs1 ? cmd_mask1    : cmd_mask0;
        sel_arg     = hs1 ? cmd_arg1     : cmd_arg0;
        sel_owner   = hs1;
        cmd_ready   = {1'b1, ready0};
    end

    // Next-state logic: a handshake replaces whatever is running and takes
    // precedence over a frame_end in the same cycle. Otherwise the frame_end
    // advances the active pattern.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so paths that
        // do not assign it hold the register value instead of inferring a latch.
        state_d = state_q;
        mask_d  = mask_q;
        owner_d = owner_q;
        lvl_d   = lvl_q;
        dir_d   = dir_q;
        phase_d = phase_q;
        flcnt_d = flcnt_q;

        if (hs_any) begin
            if (sel_pattern inside {[3'd1:3'd4]}) begin
                state_d = state_e'(sel_pattern);
                mask_d  = sel_mask;
                owner_d = sel_owner;
                lvl_d   = 8'd0;
                dir_d   = DIR_UP;
                phase_d = 1'b1;
                flcnt_d = (sel_arg == 4'd0) ? 5'd16 : {1'b0, sel_arg};
            end else begin
                // OFF and the unused codes 5..7 release the LEDs.
                state_d = ST_IDLE;
                owner_d = 1'b0;
            end
        end else if (frame_end) begin
            case (state_q)
                ST_BLINK: begin
                    phase_d = !phase_q;
                end
                ST_BREATHE: begin
                    // Each end point is held for one extra frame while the
                    // direction turns: 0..255, 255..0, 0, 1, ...
                    if (dir_q == DIR_UP) begin
                        if (lvl_q == 8'hFF) dir_d = DIR_DOWN;
                        else                lvl_d = lvl_q + 8'd1;
                    end else begin
                        if (lvl_q == 8'h00) dir_d = DIR_UP;
                        else                lvl_d = lvl_q - 8'd1;
                    end
                end
                ST_FLASH: begin
                    if (phase_q) begin
                        phase_d = 1'b0;
                    end else if (flcnt_q == 5'd1) begin
                        // The last off frame has ended, so N on frames have been shown.
                        state_d = ST_IDLE;
                        owner_d = 1'b0;
                    end else begin
                        phase_d = 1'b1;
                        flcnt_d = flcnt_q - 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State register for the prescaler, the pattern FSM and its datapath.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            cnt_q   <= '0;
            saw_q   <= 8'd0;
            state_q <= ST_IDLE;
            mask_q  <= 4'd0;
            owner_q <= 1'b0;
            lvl_q   <= 8'd0;
            dir_q   <= DIR_UP;
            phase_q <= 1'b0;
            flcnt_q <= 5'd0;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples the
            // pre-edge values no matter which order the statements are in.
            cnt_q   <= cnt_d;
            saw_q   <= saw_d;
            state_q <= state_d;
            mask_q  <= mask_d;
            owner_q <= owner_d;
            lvl_q   <= lvl_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
            flcnt_q <= flcnt_d;
        end
    end

    // Output decode from registered state. BREATHE uses a strict compare, so
    // lvl 0 is fully dark and lvl 255 is lit for 255 of 256 ticks.
    always_comb begin
        led_on = 1'b0;
        case (state_q)
            ST_SOLID:   led_on = 1'b1;
            ST_BLINK:   led_on = phase_q;
            ST_BREATHE: led_on = (lvl_q > saw_q);
            ST_FLASH:   led_on = phase_q;
            default:    led_on = 1'b0;
        endcase
        {blue, green} = {4{led_on}} & mask_q;
        busy          = (state_q != ST_IDLE);
        owner         = owner_q;
    end

endmodule

// File: tb/tb_led_pattern_sched.sv
// Self-checking bench for led_pattern_sched. It runs with TICK_DIV = 2, so
// one frame is 512 cycles. A small prescaler model locates frame boundaries.
module tb_led_pattern_sched;

    localparam int unsigned TICK_DIV = 2;
    localparam int unsigned FRAME    = TICK_DIV * 256;
    localparam int          NF_BRTH  = 96;

    logic       clk = 1'b0;
    logic       arstn = 1'b0;
    logic [1:0] cmd_valid;
    logic [1:0] cmd_ready;
    logic [2:0] cmd_pattern0, cmd_pattern1;
    logic [3:0] cmd_mask0, cmd_mask1;
    logic [3:0] cmd_arg0, cmd_arg1;
    logic [1:0] green, blue;
    logic       busy, owner;

    int n_checks = 0;
    int n_errors = 0;

    led_pattern_sched #(.TICK_DIV(TICK_DIV)) dut (
        .clk          (clk),
        .arstn        (arstn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_pattern0 (cmd_pattern0),
        .cmd_pattern1 (cmd_pattern1),
        .cmd_mask0    (cmd_mask0),
        .cmd_mask1    (cmd_mask1),
        .cmd_arg0     (cmd_arg0),
        .cmd_arg1     (cmd_arg1),
        .green        (green),
        .blue         (blue),
        .busy         (busy),
        .owner        (owner)
    );

    always #5 clk = ~clk;

    // Reference prescaler, used to predict frame_end edges.
    int unsigned m_cnt;
    logic [7:0]  m_saw;
    always @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            m_cnt <= 0;
            m_saw <= 8'd0;
        end else if (m_cnt == TICK_DIV - 1) begin
            m_cnt <= 0;
            m_saw <= m_saw + 8'd1;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    typedef struct {
        string      name;
        logic [1:0] valid;
        logic [2:0] pat0;
        logic [3:0] mask0;
        logic [3:0] arg0;
        logic [2:0] pat1;
        logic [3:0] mask1;
        logic [3:0] arg1;
        logic [1:0] exp_ready;
        logic [1:0] exp_green;
        logic [1:0] exp_blue;
        logic       exp_busy;
        logic       exp_owner;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cmd_valid    = 2'b00;
        cmd_pattern0 = 3'd0; cmd_mask0 = 4'd0; cmd_arg0 = 4'd0;
        cmd_pattern1 = 3'd0; cmd_mask1 = 4'd0; cmd_arg1 = 4'd0;
    endtask

    task automatic drive(input logic [1:0] v,
                         input logic [2:0] p0, input logic [3:0] m0, input logic [3:0] a0,
                         input logic [2:0] p1, input logic [3:0] m1, input logic [3:0] a1);
        cmd_valid    = v;
        cmd_pattern0 = p0; cmd_mask0 = m0; cmd_arg0 = a0;
        cmd_pattern1 = p1; cmd_mask1 = m1; cmd_arg1 = a1;
    endtask

    // Return on the negedge just before a frame_end posedge.
    task automatic align_frame();
        bit found = 1'b0;
        for (int i = 0; i < FRAME + 16; i++) begin
            @(negedge clk);
            if (m_cnt == TICK_DIV - 1 && m_saw == 8'hFF) begin
                found = 1'b1;
                break;
            end
        end
        check("align_frame_found", {31'd0, found}, 32'd1);
    endtask

    vec_t vecs[13];

    initial begin
        int bad;
        int on_cnt, off_cnt, runs, samples;
        logic prev;
        bit   done;
        int   exp_lvl;
        bit   exp_down;

        vecs[0]  = '{"solid_g0",      2'b01, 3'd1, 4'b0001, 4'd0, 3'd0, 4'd0,    4'd0, 2'b11, 2'b01, 2'b00, 1'b1, 1'b0};
        vecs[1]  = '{"solid_replace", 2'b01, 3'd1, 4'b1010, 4'd0, 3'd0, 4'd0,    4'd0, 2'b11, 2'b10, 2'b10, 1'b1, 1'b0};
        vecs[2]  = '{"blink_start",   2'b01, 3'd2, 4'b1111, 4'd0, 3'd0, 4'd0,    4'd0, 2'b11, 2'b11, 2'b11, 1'b1, 1'b0};
        vecs[3]  = '{"off_req0",      2'b01, 3'd0, 4'b1111, 4'd0, 3'd0, 4'd0,    4'd0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[4]  = '{"code6_is_off",  2'b01, 3'd6, 4'b1111, 4'd0, 3'd0, 4'd0,    4'd0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[5]  = '{"both_valid",    2'b11, 3'd1, 4'b1111, 4'd0, 3'd3, 4'b0010, 4'd0, 2'b10, 2'b00, 2'b00, 1'b1, 1'b1};
        vecs[6]  = '{"req0_blocked",  2'b01, 3'd1, 4'b0001, 4'd0, 3'd0, 4'd0,    4'd0, 2'b10, 2'b00, 2'b00, 1'b1, 1'b1};
        vecs[7]  = '{"req1_solid",    2'b10, 3'd0, 4'd0,    4'd0, 3'd1, 4'b0100, 4'd0, 2'b10, 2'b00, 2'b01, 1'b1, 1'b1};
        vecs[8]  = '{"req1_flash",    2'b10, 3'd0, 4'd0,    4'd0, 3'd4, 4'b1000, 4'd3, 2'b10, 2'b00, 2'b10, 1'b1, 1'b1};
        vecs[9]  = '{"code7_release", 2'b10, 3'd0, 4'd0,    4'd0, 3'd7, 4'b1111, 4'd0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[10] = '{"req0_flash",    2'b01, 3'd4, 4'b0011, 4'd1, 3'd0, 4'd0,    4'd0, 2'b11, 2'b11, 2'b00, 1'b1, 1'b0};
        vecs[11] = '{"req1_preempt",  2'b10, 3'd0, 4'd0,    4'd0, 3'd1, 4'b0011, 4'd0, 2'b10, 2'b11, 2'b00, 1'b1, 1'b1};
        vecs[12] = '{"req1_off",      2'b10, 3'd0, 4'd0,    4'd0, 3'd0, 4'd0,    4'd0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};

        idle_inputs();

        // Reset state, checked while reset is asserted and then for 2000 idle cycles.
        #1;
        check("reset_outputs", {26'd0, green, blue, busy, owner}, 32'd0);
        repeat (3) @(negedge clk);
        arstn = 1'b1;
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if ({green, blue, busy, owner} != 6'd0 || cmd_ready != 2'b11) bad++;
        end
        check("idle_2000_cycles", bad, 0);

        // Table of single-command vectors. The table starts at a frame
        // boundary so no frame_end falls inside it.
        align_frame();
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].pat0, vecs[i].mask0, vecs[i].arg0,
                  vecs[i].pat1, vecs[i].mask1, vecs[i].arg1);
            #1;
            check({vecs[i].name, "_ready"}, {30'd0, cmd_ready}, {30'd0, vecs[i].exp_ready});
            @(negedge clk);
            idle_inputs();
            #1;
            check({vecs[i].name, "_green"}, {30'd0, green}, {30'd0, vecs[i].exp_green});
            check({vecs[i].name, "_blue"},  {30'd0, blue},  {30'd0, vecs[i].exp_blue});
            check({vecs[i].name, "_busy"},  {31'd0, busy},  {31'd0, vecs[i].exp_busy});
            check({vecs[i].name, "_owner"}, {31'd0, owner}, {31'd0, vecs[i].exp_owner});
        end

        // BLINK started on a frame_end edge: the handshake wins, so the LEDs
        // are on for one full frame and then off for one full frame.
        align_frame();
        drive(2'b01, 3'd2, 4'b1111, 4'd0, 3'd0, 4'd0, 4'd0);
        on_cnt = 0; off_cnt = 0;
        for (int n = 0; n < 2 * FRAME; n++) begin
            @(negedge clk);
            if (n == 0) idle_inputs();
            if (n <  FRAME && {blue, green} == 4'hF) on_cnt++;
            if (n >= FRAME && {blue, green} == 4'h0) off_cnt++;
        end
        check("blink_on_frame", on_cnt, FRAME);
        check("blink_off_frame", off_cnt, FRAME);

        // Requester 1 FLASH x2 pre-empts the blink partway through a frame.
        repeat (100) @(negedge clk);
        drive(2'b10, 3'd0, 4'd0, 4'd0, 3'd4, 4'b0100, 4'd2);
        runs = 0; prev = 1'b0; bad = 0; done = 1'b0;
        for (int n = 0; n < 6 * FRAME; n++) begin
            @(negedge clk);
            if (n == 0) idle_inputs();
            if (!busy) begin
                done = 1'b1;
                break;
            end
            if (cmd_ready[0] || !owner || green != 2'b00 || blue[1]) bad++;
            if (blue[0] && !prev) runs++;
            prev = blue[0];
        end
        check("flash2_finished", {31'd0, done}, 32'd1);
        check("flash2_on_frames", runs, 2);
        check("flash2_ready0_low", bad, 0);
        check("flash2_idle_outputs", {26'd0, green, blue, busy, owner}, 32'd0);
        check("flash2_ready_back", {30'd0, cmd_ready}, 32'd3);

        // BREATHE started on a frame_end edge. Count the lit cycles of
        // green[1] in each frame against a model of the lvl sequence.
        align_frame();
        drive(2'b01, 3'd3, 4'b0010, 4'd0, 3'd0, 4'd0, 4'd0);
        exp_lvl = 0; exp_down = 1'b0;
        for (int k = 0; k < NF_BRTH; k++) begin
            on_cnt = 0; bad = 0;
            for (int n = 0; n < FRAME; n++) begin
                @(negedge clk);
                if (k == 0 && n == 0) idle_inputs();
                if (green[1]) on_cnt++;
                if (green[0] || blue != 2'b00 || !busy) bad++;
            end
            check($sformatf("breathe_frame%0d_duty", k), on_cnt, exp_lvl * TICK_DIV);
            if (bad != 0) check($sformatf("breathe_frame%0d_other", k), bad, 0);
            if (!exp_down) begin
                if (exp_lvl == 255) exp_down = 1'b1; else exp_lvl++;
            end else begin
                if (exp_lvl == 0) exp_down = 1'b0; else exp_lvl--;
            end
        end
        @(negedge clk);
        drive(2'b01, 3'd0, 4'd0, 4'd0, 3'd0, 4'd0, 4'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("breathe_off_busy", {31'd0, busy}, 32'd0);

        // FLASH with arg 0 means 16 flashes: 16 on frames and 16 off frames, then IDLE.
        align_frame();
        drive(2'b10, 3'd0, 4'd0, 4'd0, 3'd4, 4'b1111, 4'd0);
        runs = 0; prev = 1'b0; on_cnt = 0; samples = 0; done = 1'b0;
        for (int n = 0; n < 40 * FRAME; n++) begin
            @(negedge clk);
            if (n == 0) idle_inputs();
            if (!busy) begin
                done = 1'b1;
                break;
            end
            samples++;
            if ({blue, green} == 4'hF) on_cnt++;
            if (green[0] && !prev) runs++;
            prev = green[0];
        end
        check("flash16_finished", {31'd0, done}, 32'd1);
        check("flash16_on_frames", runs, 16);
        check("flash16_on_cycles", on_cnt, 16 * FRAME);
        check("flash16_busy_cycles", samples, 32 * FRAME);
        check("flash16_owner_idle", {31'd0, owner}, 32'd0);

        // Reset asserted mid-flash clears the outputs without waiting for a clock edge.
        align_frame();
        drive(2'b10, 3'd0, 4'd0, 4'd0, 3'd4, 4'b1111, 4'd0);
        @(negedge clk);
        idle_inputs();
        repeat (100) @(negedge clk);
        check("midflash_lit", {28'd0, blue, green}, 32'hF);
        #2;
        arstn = 1'b0;
        #1;
        check("async_reset_outputs", {26'd0, green, blue, busy, owner}, 32'd0);
        repeat (3) @(negedge clk);
        arstn = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_idle", {26'd0, green, blue, busy, owner}, 32'd0);
        check("post_reset_ready", {30'd0, cmd_ready}, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
